spi_slave_if: RTL and testbench

- Serial front end of the SPI slave; sits directly upstream of the single-port sync RAM.
- Deserialises MOSI into 10-bit command/data words and delivers each as rx_data with a one-cycle rx_valid pulse.
- Serialises the RAM's 8-bit read data, presented on tx_data/tx_valid, back out on MISO.
- System clock is the SPI bit clock: one bit per clk edge, MSB first.

---
 rtl/spi_pkg.sv | 39 +++
 rtl/spi_tx_shifter.sv | 54 +++++
 rtl/spi_slave_if.sv | 134 +++++++++++++
 tb/tb_spi_slave_if.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

   localparam int unsigned RX_W_DEF = 10;
   localparam int unsigned TX_W_DEF = 8;
   localparam int unsigned CNT_W    = 4;

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } spi_state_e;

   // Sub-phase inside WRITE / READ_ADD / READ_DATA
   typedef enum logic [1:0] {
      PH_RX,
      PH_WAIT,
      PH_TX,
      PH_DONE
   } spi_phase_e;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   // True when a completed word's opcode is legal for the state that received it
   function automatic logic opcode_ok(input spi_state_e st, input logic [1:0] op);
      case (st)
         WRITE:     return (op == OP_WR_ADDR) || (op == OP_WR_DATA);
         READ_ADD:  return op == OP_RD_ADDR;
         READ_DATA: return op == OP_RD_DATA;
         default:   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Loads RAM read data and shifts it MSB-first onto MISO over TX_W cycles.
module spi_tx_shifter
   import spi_pkg::*;
#(
   parameter int unsigned TX_W = TX_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            load,
   input  logic [TX_W-1:0] din,
   output logic            miso,
   output logic            done_c
);

   localparam int unsigned        TXC_W = $clog2(TX_W);
   localparam logic [TXC_W-1:0]   LAST  = TXC_W'(TX_W - 1);

   logic [TX_W-1:0]  sh;
   logic [TXC_W-1:0] cnt;
   logic             busy;

   // Last active edge: miso drops back to 0 here
   assign done_c = busy && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh   <= '0;
         cnt  <= '0;
         busy <= 1'b0;
         miso <= 1'b0;
      end else if (clr) begin
         sh   <= '0;
         cnt  <= '0;
         busy <= 1'b0;
         miso <= 1'b0;
      end else if (load) begin
         sh   <= {din[TX_W-2:0], 1'b0};
         cnt  <= '0;
         busy <= 1'b1;
         miso <= din[TX_W-1];
      end else if (busy) begin
         if (cnt == LAST) begin
            busy <= 1'b0;
            miso <= 1'b0;
         end else begin
            miso <= sh[TX_W-1];
            sh   <= {sh[TX_W-2:0], 1'b0};
            cnt  <= cnt + TXC_W'(1);
         end
      end
   end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave serial front end: MOSI -> rx_data words, RAM read data -> MISO.
// Optional SPI_OPCODE_CHECK_EN drops words whose opcode does not fit the state.
module spi_slave_if
   import spi_pkg::*;
#(
   parameter int unsigned RX_W = RX_W_DEF,
   parameter int unsigned TX_W = TX_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            SS_n,
   input  logic            MOSI,
   output logic            MISO,
   output logic [RX_W-1:0] rx_data,
   output logic            rx_valid,
   input  logic [TX_W-1:0] tx_data,
   input  logic            tx_valid
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(RX_W - 1);

   spi_state_e       state, state_nxt;
   spi_phase_e       phase, phase_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [RX_W-2:0]  rx_sh, rx_sh_nxt;
   logic [RX_W-1:0]  rx_data_nxt;
   logic             rx_valid_nxt;
   logic             rd_addr_seen, rd_addr_seen_nxt;
   logic [RX_W-1:0]  word;
   logic             word_ok;
   logic             load_c;
   logic             done_c;

   assign word = {rx_sh, MOSI};

`ifdef SPI_OPCODE_CHECK_EN
   assign word_ok = opcode_ok(state, word[RX_W-1 -: 2]);
`else
   assign word_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         phase        <= PH_RX;
         cnt          <= '0;
         rx_sh        <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rd_addr_seen <= 1'b0;
      end else begin
         state        <= state_nxt;
         phase        <= phase_nxt;
         cnt          <= cnt_nxt;
         rx_sh        <= rx_sh_nxt;
         rx_data      <= rx_data_nxt;
         rx_valid     <= rx_valid_nxt;
         rd_addr_seen <= rd_addr_seen_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (state != IDLE && SS_n) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (!SS_n) state_nxt = CHK_CMD;
            CHK_CMD: state_nxt = !MOSI ? WRITE : (rd_addr_seen ? READ_DATA : READ_ADD);
            default: state_nxt = state;
         endcase
      end
   end

   always_comb begin
      phase_nxt        = phase;
      cnt_nxt          = cnt;
      rx_sh_nxt        = rx_sh;
      rx_data_nxt      = rx_data;
      rx_valid_nxt     = 1'b0;
      rd_addr_seen_nxt = rd_addr_seen;
      load_c           = 1'b0;
      if (state == IDLE || SS_n) begin
         phase_nxt = PH_RX;
         cnt_nxt   = '0;
         rx_sh_nxt = '0;
      end else if (state == CHK_CMD) begin
         phase_nxt = PH_RX;
         rx_sh_nxt = (RX_W - 1)'(MOSI);
         cnt_nxt   = CNT_W'(1);
      end else begin
         case (phase)
            PH_RX: begin
               rx_sh_nxt = {rx_sh[RX_W-3:0], MOSI};
               cnt_nxt   = cnt + CNT_W'(1);
               if (cnt == LAST_BIT) begin
                  cnt_nxt   = '0;
                  phase_nxt = PH_DONE;
                  if (word_ok) begin
                     rx_data_nxt  = word;
                     rx_valid_nxt = 1'b1;
                     if (state == READ_ADD)  rd_addr_seen_nxt = 1'b1;
                     if (state == READ_DATA) phase_nxt = PH_WAIT;
                  end
               end
            end
            PH_WAIT: begin
               if (tx_valid) begin
                  load_c    = 1'b1;
                  phase_nxt = PH_TX;
               end
            end
            PH_TX: begin
               if (done_c) begin
                  rd_addr_seen_nxt = 1'b0;
                  phase_nxt        = PH_DONE;
               end
            end
            default: phase_nxt = phase;
         endcase
      end
   end

   spi_tx_shifter #(.TX_W(TX_W)) u_tx (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (SS_n),
      .load   (load_c),
      .din    (tx_data),
      .miso   (MISO),
      .done_c (done_c)
   );

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if with a received-word scoreboard and a tiny RAM model.
module tb_spi_slave_if;
   import spi_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n, SS_n, MOSI, MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data, rd_val;
   logic       tx_valid, ram_tv, frc_tv;

   logic [9:0] exp_q[$];
   int         tests = 0;
   int         fails = 0;
   int         pulses = 0;

   always #5 clk = ~clk;

   spi_slave_if dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
   );

   // RAM model: answers a read-data word one cycle after its rx_valid
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_tv  <= 1'b0;
         tx_data <= 8'h00;
      end else begin
         ram_tv  <= rx_valid && (rx_data[9:8] == OP_RD_DATA);
         tx_data <= rd_val;
      end
   end
   assign tx_valid = ram_tv | frc_tv;

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every rx_valid pulse must match the next queued word
   always @(posedge clk) begin
      #1;
      if (rx_valid === 1'b1) begin
         pulses++;
         if (exp_q.size() == 0) chk("rx_unexpected", 10'(rx_valid), 10'd0);
         else                   chk("rx_data", rx_data, exp_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [9:0] w, input int nbits, input logic expv);
      if (expv) exp_q.push_back(w);
      SS_n = 1'b0;
      tick();
      for (int i = 0; i < nbits; i++) begin
         MOSI = w[9-i];
         tick();
         chk("miso_quiet_rx", 10'(MISO), 10'd0);
      end
      chk("rx_valid_strobe", 10'(rx_valid), 10'(expv));
   endtask

   task automatic end_frame();
      SS_n = 1'b1;
      MOSI = 1'b0;
      tick();
   endtask

   task automatic expect_miso(input logic [7:0] v);
      tick();
      chk("tx_valid_seen", 10'(tx_valid), 10'd1);
      chk("miso_wait", 10'(MISO), 10'd0);
      for (int i = 7; i >= 0; i--) begin
         tick();
         chk("miso_bit", 10'(MISO), 10'(v[i]));
      end
      tick();
      chk("miso_after", 10'(MISO), 10'd0);
      chk("rd_addr_cleared", 10'(dut.rd_addr_seen), 10'd0);
   endtask

   initial begin
      logic any_miso;
      int   p0;
      logic exp_op;
      rst_n  = 1'b0;
      SS_n   = 1'b1;
      MOSI   = 1'b0;
      frc_tv = 1'b0;
      rd_val = 8'h5A;
      tick();
      tick();
      chk("reset_miso", 10'(MISO), 10'd0);
      chk("reset_rx_valid", 10'(rx_valid), 10'd0);
      chk("reset_rx_data", rx_data, 10'd0);
      chk("reset_state", 10'(dut.state), 10'(IDLE));
      chk("reset_rd_addr", 10'(dut.rd_addr_seen), 10'd0);
      rst_n = 1'b1;
      tick();

      // Write address, then confirm the strobe is one cycle and data holds
      send(10'h0A5, 10, 1'b1);
      tick();
      chk("rx_valid_one_cycle", 10'(rx_valid), 10'd0);
      chk("rx_data_hold", rx_data, 10'h0A5);
      end_frame();

      send(10'h1FF, 10, 1'b1);
      end_frame();

      // Read address then read data with MISO shift-out
      send(10'h2A5, 10, 1'b1);
      chk("rd_addr_set", 10'(dut.rd_addr_seen), 10'd1);
      end_frame();
      send(10'h300, 10, 1'b1);
      expect_miso(8'h5A);
      end_frame();

      // Abort after five bits of a write
      p0 = pulses;
      send(10'h0F0, 5, 1'b0);
      end_frame();
      chk("abort_state", 10'(dut.state), 10'(IDLE));
      chk("abort_no_pulse", 10'(pulses - p0), 10'd0);
      send(10'h012, 10, 1'b1);
      end_frame();

      // Reset in the middle of the MISO shift
      send(10'h2A5, 10, 1'b1);
      end_frame();
      send(10'h300, 10, 1'b1);
      repeat (6) tick();
      chk("miso_bit3_pre_reset", 10'(MISO), 10'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_miso", 10'(MISO), 10'd0);
      chk("async_rst_rx_valid", 10'(rx_valid), 10'd0);
      chk("async_rst_rd_addr", 10'(dut.rd_addr_seen), 10'd0);
      SS_n = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();

      // After reset a read frame is a read-address frame; tx_valid is ignored
      send(10'h2C3, 10, 1'b1);
      chk("post_reset_read_add", 10'(dut.state), 10'(READ_ADD));
      frc_tv   = 1'b1;
      tick();
      frc_tv   = 1'b0;
      any_miso = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         any_miso |= MISO;
      end
      chk("read_add_ignores_tx", 10'(any_miso), 10'd0);
      end_frame();
      rd_val = 8'hC3;
      send(10'h300, 10, 1'b1);
      expect_miso(8'hC3);
      end_frame();

      // Read-data opcode arriving in READ_ADD
`ifdef SPI_OPCODE_CHECK_EN
      exp_op = 1'b0;
`else
      exp_op = 1'b1;
`endif
      send(10'h3A5, 10, exp_op);
      chk("opcode_rd_addr_seen", 10'(dut.rd_addr_seen), 10'(exp_op));
      end_frame();
      tick();
      tick();

      chk("scoreboard_drain", 10'(exp_q.size()), 10'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
